// File: rtl/dmem_waitstate_if.sv
// Request/response bundle between a core's data port and dmem_waitstate.
interface dmem_waitstate_if;
   logic        req;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        ready;
   logic        err;
   logic        busy;

   modport master (
      output req, we, funct3, addr, wd,
      input  rd, ready, err, busy
   );

   modport slave (
      input  req, we, funct3, addr, wd,
      output rd, ready, err, busy
   );
endinterface

// File: rtl/dmem_waitstate.sv
// Data memory with byte/halfword/word access, configurable wait states and
// a req/ready handshake. Requests are captured in IDLE, held for WAIT extra
// cycles, then performed; the result is presented for exactly one cycle.
module dmem_waitstate #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WAIT      = 0,
  parameter string       INIT_FILE = ""
) (
  input logic             clk,
  input logic             reset,
  dmem_waitstate_if.slave bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          capture;
  logic          finish;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wd_q;

  logic [31:0]   rd_q;
  logic          ready_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          in_range;
  logic          misaligned;
  logic          bad_f3;
  logic          acc_err;
  logic          do_write;
  logic [31:0]   word;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   load_val;
  logic [31:0]   wdata;
  logic [3:0]    wmask;

  assign widx     = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign in_range = (addr_q[31:AW+2] == '0);
  assign word     = mem[widx];

  // Decode the captured request: legality, load extraction, store lane mask.
  always_comb begin
    if (we_q)
      bad_f3 = f3_q[2] || (f3_q[1:0] == 2'b11);
    else
      bad_f3 = (f3_q[1:0] == 2'b11) || (f3_q == 3'b110);

    misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));

    acc_err = bad_f3 || misaligned || !in_range;

    lb = word[{lane, 3'b000} +: 8];
    lh = addr_q[1] ? word[31:16] : word[15:0];

    case (f3_q[1:0])
      2'b00:   load_val = {{24{lb[7] & ~f3_q[2]}}, lb};
      2'b01:   load_val = {{16{lh[15] & ~f3_q[2]}}, lh};
      default: load_val = word;
    endcase

    case (f3_q[1:0])
      2'b00: begin
        wmask = 4'b0001 << lane;
        wdata = {4{wd_q[7:0]}};
      end
      2'b01: begin
        wmask = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd_q[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wdata = wd_q;
      end
    endcase
  end

  assign do_write = finish && we_q && !acc_err;

  // State and wait counter; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAITING, one RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          capture = 1'b1;
          cnt_d   = WAIT_CNT;
          state_d = WAITING;
        end
      end
      WAITING: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          finish  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and registered response; stores and errors return zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        we_q   <= bus.we;
        f3_q   <= bus.funct3;
        addr_q <= bus.addr;
        wd_q   <= bus.wd;
      end
      ready_q <= finish;
      if (finish) begin
        err_q <= acc_err;
        rd_q  <= (acc_err || we_q) ? '0 : load_val;
      end
    end
  end

  // RAM write port: only selected byte lanes are updated.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wmask[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bus.rd    = rd_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_waitstate.sv
// Bench for dmem_waitstate: four instances with WAIT = 0..3 against a
// byte-array reference model.
module tb_dmem_waitstate;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        req_s  [4];
   logic        we_s   [4];
   logic [2:0]  f3_s   [4];
   logic [31:0] addr_s [4];
   logic [31:0] wd_s   [4];
   logic [31:0] rd_o   [4];
   logic        ready_o[4];
   logic        err_o  [4];
   logic        busy_o [4];

   logic [7:0]  mm [4][256];

   for (genvar g = 0; g < 4; g++) begin : gi
      dmem_waitstate_if bus ();
      dmem_waitstate #(.DEPTH(64), .WAIT(g), .INIT_FILE("")) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus.slave)
      );
      assign bus.req    = req_s[g];
      assign bus.we     = we_s[g];
      assign bus.funct3 = f3_s[g];
      assign bus.addr   = addr_s[g];
      assign bus.wd     = wd_s[g];
      assign rd_o[g]    = bus.rd;
      assign ready_o[g] = bus.ready;
      assign err_o[g]   = bus.err;
      assign busy_o[g]  = bus.busy;
   end

   typedef struct {
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] x;
      logic        e;
   } op_t;

   function automatic op_t mk(input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] x, input logic e);
      op_t o;
      o.w = w; o.f3 = f3; o.a = a; o.d = d; o.x = x; o.e = e;
      return o;
   endfunction

   // Reference: byte-addressed little-endian array, rules applied directly.
   function automatic void model_access(input int k, input logic w,
                                        input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] d,
                                        output logic [31:0] r,
                                        output logic e);
      int n;
      bit legal;
      logic [31:0] v;
      logic [31:0] t;
      n = 1 << f3[1:0];
      if (w) legal = (f3 <= 3'd2);
      else   legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      e = !legal || ((a % n) != 0) || ((a / 4) >= 64);
      r = 32'h0;
      if (e) return;
      if (w) begin
         for (int i = 0; i < n; i++) begin
            t = d >> (8 * i);
            mm[k][int'(a) + i] = t[7:0];
         end
      end else begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = v | (32'(mm[k][int'(a) + i]) << (8 * i));
         if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
         r = v;
      end
   endfunction

   // Drives one request and reports what came back; lat = 0 means no ready.
   task automatic run_access(input int k, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] r, output logic e,
                             output int lat, output int bc,
                             output logic pr, output logic pb);
      @(negedge clk);
      we_s[k] = w; f3_s[k] = f3; addr_s[k] = a; wd_s[k] = d; req_s[k] = 1'b1;
      @(posedge clk);
      #1 req_s[k] = 1'b0;
      lat = 0; bc = 0; r = 'x; e = 1'bx;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy_o[k] === 1'b1) bc++;
         if (ready_o[k] === 1'b1) begin
            lat = c; r = rd_o[k]; e = err_o[k];
            break;
         end
      end
      @(negedge clk);
      pr = ready_o[k];
      pb = busy_o[k];
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++; if (rd_o[k] !== 32'h0) begin failures++; $display("FAIL reset_rd[%0d]: got %h expected %h", k, rd_o[k], 32'h0); end
         checks++; if (ready_o[k] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, ready_o[k]); end
         checks++; if (err_o[k] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d]: got %b expected 0", k, err_o[k]); end
         checks++; if (busy_o[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_o[k]); end
      end
      reset = 1'b0;
   endtask

   // WAIT=2: ready in the 4th cycle after acceptance, busy through RESP.
   task automatic test_wait2;
      op_t ops[$];
      logic [31:0] r, mr;
      logic e, me, pr, pb;
      int lat, bc;
      ops.push_back(mk(1'b1, 3'b010, 32'h54, 32'h47, 32'h0, 1'b0));
      ops.push_back(mk(1'b0, 3'b010, 32'h54, 32'h0, 32'h47, 1'b0));
      foreach (ops[i]) begin
         model_access(2, ops[i].w, ops[i].f3, ops[i].a, ops[i].d, mr, me);
         run_access(2, ops[i].w, ops[i].f3, ops[i].a, ops[i].d, r, e, lat, bc, pr, pb);
         checks++; if (lat != 4) begin failures++; $display("FAIL w2_latency[%0d]: got %0d expected 4", i, lat); end
         checks++; if (bc != 4) begin failures++; $display("FAIL w2_busy_cycles[%0d]: got %0d expected 4", i, bc); end
         checks++; if (e !== ops[i].e) begin failures++; $display("FAIL w2_err[%0d]: got %b expected %b", i, e, ops[i].e); end
         checks++; if (pr !== 1'b0 || pb !== 1'b0) begin failures++; $display("FAIL w2_after_resp[%0d]: ready=%b busy=%b expected 0 0", i, pr, pb); end
         if (!ops[i].w) begin
            checks++; if (r !== ops[i].x) begin failures++; $display("FAIL w2_rd[%0d]: got %h expected %h", i, r, ops[i].x); end
         end
      end
   endtask

   // WAIT=0: sub-word stores and loads with sign/zero extension.
   task automatic test_byte_half;
      op_t ops[$];
      logic [31:0] r, mr;
      logic e, me, pr, pb;
      int lat, bc;
      ops.push_back(mk(1'b1, 3'b010, 32'h54, 32'h0000_0047, 32'h0, 1'b0));
      ops.push_back(mk(1'b1, 3'b000, 32'h55, 32'h1234_56AB, 32'h0, 1'b0));
      ops.push_back(mk(1'b0, 3'b010, 32'h54, 32'h0, 32'h0000_AB47, 1'b0));
      ops.push_back(mk(1'b0, 3'b000, 32'h55, 32'h0, 32'hFFFF_FFAB, 1'b0));
      ops.push_back(mk(1'b0, 3'b100, 32'h55, 32'h0, 32'h0000_00AB, 1'b0));
      ops.push_back(mk(1'b1, 3'b001, 32'h56, 32'h0000_8001, 32'h0, 1'b0));
      ops.push_back(mk(1'b0, 3'b001, 32'h56, 32'h0, 32'hFFFF_8001, 1'b0));
      ops.push_back(mk(1'b0, 3'b101, 32'h56, 32'h0, 32'h0000_8001, 1'b0));
      ops.push_back(mk(1'b0, 3'b010, 32'h54, 32'h0, 32'h8001_AB47, 1'b0));
      foreach (ops[i]) begin
         model_access(0, ops[i].w, ops[i].f3, ops[i].a, ops[i].d, mr, me);
         run_access(0, ops[i].w, ops[i].f3, ops[i].a, ops[i].d, r, e, lat, bc, pr, pb);
         checks++; if (lat != 2) begin failures++; $display("FAIL bh_latency[%0d]: got %0d expected 2", i, lat); end
         checks++; if (e !== ops[i].e) begin failures++; $display("FAIL bh_err[%0d]: got %b expected %b", i, e, ops[i].e); end
         checks++; if (pr !== 1'b0) begin failures++; $display("FAIL bh_ready_width[%0d]: got %b expected 0", i, pr); end
         if (!ops[i].w) begin
            checks++; if (r !== ops[i].x) begin failures++; $display("FAIL bh_rd[%0d]: got %h expected %h", i, r, ops[i].x); end
         end
      end
   endtask

   // Rejected accesses: same latency, err=1, rd=0, memory untouched.
   task automatic test_errors;
      op_t ops[$];
      logic [31:0] r, mr;
      logic e, me, pr, pb;
      int lat, bc;
      ops.push_back(mk(1'b0, 3'b010, 32'h52,  32'h0,         32'h0, 1'b1));
      ops.push_back(mk(1'b1, 3'b001, 32'h57,  32'h0000_FFFF, 32'h0, 1'b1));
      ops.push_back(mk(1'b1, 3'b010, 32'h100, 32'hCAFE_F00D, 32'h0, 1'b1));
      ops.push_back(mk(1'b1, 3'b100, 32'h54,  32'h0000_0000, 32'h0, 1'b1));
      ops.push_back(mk(1'b0, 3'b010, 32'h54,  32'h0,         32'h8001_AB47, 1'b0));
      foreach (ops[i]) begin
         model_access(0, ops[i].w, ops[i].f3, ops[i].a, ops[i].d, mr, me);
         run_access(0, ops[i].w, ops[i].f3, ops[i].a, ops[i].d, r, e, lat, bc, pr, pb);
         checks++; if (lat != 2) begin failures++; $display("FAIL er_latency[%0d]: got %0d expected 2", i, lat); end
         checks++; if (e !== ops[i].e) begin failures++; $display("FAIL er_err[%0d]: got %b expected %b", i, e, ops[i].e); end
         if (!ops[i].w || ops[i].e) begin
            checks++; if (r !== ops[i].x) begin failures++; $display("FAIL er_rd[%0d]: got %h expected %h", i, r, ops[i].x); end
         end
      end
   endtask

   // WAIT=1 with req held high: accept every 4 edges, 1-cycle ready pulses.
   task automatic test_back_to_back;
      int rdy_idx[$];
      int acc_idx[$];
      logic prev_busy;
      logic [31:0] d, mr;
      logic me;
      d = $urandom;
      @(negedge clk);
      we_s[1] = 1'b1; f3_s[1] = 3'b010; addr_s[1] = 32'h20; wd_s[1] = d; req_s[1] = 1'b1;
      prev_busy = busy_o[1];
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (busy_o[1] === 1'b1 && prev_busy !== 1'b1) acc_idx.push_back(c);
         prev_busy = busy_o[1];
         if (ready_o[1] === 1'b1) begin
            rdy_idx.push_back(c);
            checks++; if (err_o[1] !== 1'b0) begin failures++; $display("FAIL b2b_err@%0d: got %b expected 0", c, err_o[1]); end
         end
      end
      req_s[1] = 1'b0;
      repeat (6) @(negedge clk);
      model_access(1, 1'b1, 3'b010, 32'h20, d, mr, me);
      checks++; if (rdy_idx.size() != 10) begin failures++; $display("FAIL b2b_ready_count: got %0d expected 10", rdy_idx.size()); end
      checks++; if (acc_idx.size() != 10) begin failures++; $display("FAIL b2b_accept_count: got %0d expected 10", acc_idx.size()); end
      if (rdy_idx.size() > 0) begin
         checks++; if (rdy_idx[0] != 2) begin failures++; $display("FAIL b2b_first_ready: got %0d expected 2", rdy_idx[0]); end
      end
      for (int i = 1; i < rdy_idx.size(); i++) begin
         checks++; if (rdy_idx[i] - rdy_idx[i-1] != 4) begin failures++; $display("FAIL b2b_ready_gap[%0d]: got %0d expected 4", i, rdy_idx[i] - rdy_idx[i-1]); end
      end
      for (int i = 1; i < acc_idx.size(); i++) begin
         checks++; if (acc_idx[i] - acc_idx[i-1] != 4) begin failures++; $display("FAIL b2b_accept_gap[%0d]: got %0d expected 4", i, acc_idx[i] - acc_idx[i-1]); end
      end
   endtask

   // WAIT=3: reset two cycles after acceptance cancels the pending store.
   task automatic test_reset_mid;
      logic [31:0] r, mr;
      logic e, me, pr, pb;
      int lat, bc;
      model_access(3, 1'b1, 3'b010, 32'h10, 32'h1122_3344, mr, me);
      run_access(3, 1'b1, 3'b010, 32'h10, 32'h1122_3344, r, e, lat, bc, pr, pb);
      checks++; if (e !== 1'b0 || lat != 5) begin failures++; $display("FAIL rm_setup: err=%b lat=%0d expected 0 5", e, lat); end
      @(negedge clk);
      we_s[3] = 1'b1; f3_s[3] = 3'b010; addr_s[3] = 32'h10; wd_s[3] = 32'hDEAD_BEEF; req_s[3] = 1'b1;
      @(posedge clk);
      #1 req_s[3] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++; if (busy_o[3] !== 1'b1) begin failures++; $display("FAIL rm_busy_before: got %b expected 1", busy_o[3]); end
      reset = 1'b1;
      #1;
      checks++; if (busy_o[3] !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b expected 0", busy_o[3]); end
      checks++; if (ready_o[3] !== 1'b0) begin failures++; $display("FAIL rm_ready: got %b expected 0", ready_o[3]); end
      checks++; if (err_o[3] !== 1'b0) begin failures++; $display("FAIL rm_err: got %b expected 0", err_o[3]); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_access(3, 1'b0, 3'b010, 32'h10, 32'h0, mr, me);
      run_access(3, 1'b0, 3'b010, 32'h10, 32'h0, r, e, lat, bc, pr, pb);
      checks++; if (r !== 32'h1122_3344) begin failures++; $display("FAIL rm_rd_after: got %h expected %h", r, 32'h1122_3344); end
      checks++; if (e !== 1'b0 || lat != 5) begin failures++; $display("FAIL rm_after: err=%b lat=%0d expected 0 5", e, lat); end
   endtask

   // Random mix of sizes, directions, lanes and illegal/out-of-range cases.
   task automatic test_random;
      logic [31:0] r, mr, a, d;
      logic e, me, pr, pb, w;
      logic [2:0] f3;
      int lat, bc;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model_access(k, 1'b1, 3'b010, 32'(4 * i), d, mr, me);
            run_access(k, 1'b1, 3'b010, 32'(4 * i), d, r, e, lat, bc, pr, pb);
            checks++; if (e !== 1'b0 || lat != k + 2) begin failures++; $display("FAIL rnd_init[%0d][%0d]: err=%b lat=%0d expected 0 %0d", k, i, e, lat, k + 2); end
         end
         for (int i = 0; i < 50; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            d  = $urandom;
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h100;
            else a = 32'($urandom_range(0, 63));
            model_access(k, w, f3, a, d, mr, me);
            run_access(k, w, f3, a, d, r, e, lat, bc, pr, pb);
            checks++; if (e !== me) begin failures++; $display("FAIL rnd_err[%0d][%0d]: got %b expected %b (we=%b f3=%0d a=%h)", k, i, e, me, w, f3, a); end
            checks++; if (lat != k + 2 || pr !== 1'b0) begin failures++; $display("FAIL rnd_timing[%0d][%0d]: lat=%0d ready_after=%b expected %0d 0", k, i, lat, pr, k + 2); end
            if (!w || me) begin
               checks++; if (r !== mr) begin failures++; $display("FAIL rnd_rd[%0d][%0d]: got %h expected %h (f3=%0d a=%h)", k, i, r, mr, f3, a); end
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         req_s[k] = 1'b0; we_s[k] = 1'b0; f3_s[k] = 3'b010; addr_s[k] = '0; wd_s[k] = '0;
      end
      test_reset();
      test_wait2();
      test_byte_half();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
